// File: rtl/uart_pkg.sv
// Shared UART types and constants.
// Receiver state encoding, legal prescales and parity modes.
package uart_pkg;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_PARITY,
    RX_STOP
  } rx_state_e;

  localparam logic [5:0] PRESCALE_8  = 6'd8;
  localparam logic [5:0] PRESCALE_16 = 6'd16;
  localparam logic [5:0] PRESCALE_32 = 6'd32;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  function automatic logic maj3(input logic [2:0] s);
    return (s[0] & s[1]) | (s[0] & s[2]) | (s[1] & s[2]);
  endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Bit-time counter and 3-sample majority vote around mid-bit.
// sample_done fires once the vote is settled, bit_end on wrap.
module uart_rx_sampler
  import uart_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       run,
  input  logic       rx,
  input  logic [5:0] prescale,
  output logic       bit_val,
  output logic       sample_done,
  output logic       bit_end
);

  logic [5:0] half;
  logic [5:0] edge_cnt_d, edge_cnt_q;
  logic [2:0] samp_d, samp_q;

  assign half        = prescale >> 1;
  assign bit_end     = run && (edge_cnt_q == prescale - 6'd1);
  assign sample_done = run && (edge_cnt_q == half + 6'd2);
  assign bit_val     = maj3(samp_q);

  // Held at zero while idle so a new frame always starts aligned.
  always_comb begin
    edge_cnt_d = '0;
    if (run && !bit_end) edge_cnt_d = edge_cnt_q + 6'd1;
  end

  always_comb begin
    samp_d = samp_q;
    if (run) begin
      if (edge_cnt_q == half - 6'd1) samp_d[0] = rx;
      if (edge_cnt_q == half)        samp_d[1] = rx;
      if (edge_cnt_q == half + 6'd1) samp_d[2] = rx;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      edge_cnt_q <= '0;
      samp_q     <= 3'b111;
    end else begin
      edge_cnt_q <= edge_cnt_d;
      samp_q     <= samp_d;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// Oversampling UART receiver with optional parity.
// Frame config is latched at start-bit detection.
module uart_rx
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  RX_IN,
  input  logic [5:0]            Prescale,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  output logic [DATA_WIDTH-1:0] P_DATA,
  output logic                  Data_valid,
  output logic                  Par_err,
  output logic                  Stp_err
);

  localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH - 1);

  logic [1:0]            sync_q;
  logic                  rx;
  rx_state_e             state_d, state_q;
  logic [BW-1:0]         bit_cnt_d, bit_cnt_q;
  logic [DATA_WIDTH-1:0] shift_d, shift_q;
  logic [DATA_WIDTH-1:0] p_data_d, p_data_q;
  logic [5:0]            presc_d, presc_q;
  logic                  par_en_d, par_en_q;
  logic                  par_typ_d, par_typ_q;
  logic                  par_fail_d, par_fail_q;
  logic                  dv_d, dv_q;
  logic                  pe_d, pe_q;
  logic                  se_d, se_q;
  logic                  bit_val, sample_done, bit_end;

  assign rx = sync_q[1];

  uart_rx_sampler u_sampler (
    .clk        (CLK),
    .rst_n      (RST),
    .run        (state_q != RX_IDLE),
    .rx         (rx),
    .prescale   (presc_q),
    .bit_val    (bit_val),
    .sample_done(sample_done),
    .bit_end    (bit_end)
  );

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    p_data_d   = p_data_q;
    presc_d    = presc_q;
    par_en_d   = par_en_q;
    par_typ_d  = par_typ_q;
    par_fail_d = par_fail_q;
    dv_d       = 1'b0;
    pe_d       = 1'b0;
    se_d       = 1'b0;
    unique case (state_q)
      RX_IDLE: begin
        if (!rx) begin
          state_d    = RX_START;
          presc_d    = Prescale;
          par_en_d   = PAR_EN;
          par_typ_d  = PAR_TYP;
          par_fail_d = 1'b0;
          bit_cnt_d  = '0;
        end
      end
      RX_START: begin
        if (sample_done && bit_val) state_d = RX_IDLE;
        else if (bit_end)           state_d = RX_DATA;
      end
      RX_DATA: begin
        if (sample_done)
          shift_d = DATA_WIDTH'({bit_val, shift_q} >> 1);
        if (bit_end) begin
          if (bit_cnt_q == LAST_BIT)
            state_d = par_en_q ? RX_PARITY : RX_STOP;
          else
            bit_cnt_d = bit_cnt_q + BW'(1);
        end
      end
      RX_PARITY: begin
        if (sample_done)
          par_fail_d = bit_val != (^shift_q ^ par_typ_q);
        if (bit_end) state_d = RX_STOP;
      end
      RX_STOP: begin
        // Leave early so a start bit right after stop is caught.
        if (sample_done) begin
          state_d = RX_IDLE;
          dv_d    = bit_val & ~par_fail_q;
          pe_d    = par_fail_q;
          se_d    = ~bit_val;
          if (bit_val && !par_fail_q) p_data_d = shift_q;
        end else if (bit_end) begin
          state_d = RX_IDLE;
        end
      end
      default: state_d = RX_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      sync_q     <= 2'b11;
      state_q    <= RX_IDLE;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      p_data_q   <= '0;
      presc_q    <= PRESCALE_8;
      par_en_q   <= 1'b0;
      par_typ_q  <= PAR_EVEN;
      par_fail_q <= 1'b0;
      dv_q       <= 1'b0;
      pe_q       <= 1'b0;
      se_q       <= 1'b0;
    end else begin
      sync_q     <= {sync_q[0], RX_IN};
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      p_data_q   <= p_data_d;
      presc_q    <= presc_d;
      par_en_q   <= par_en_d;
      par_typ_q  <= par_typ_d;
      par_fail_q <= par_fail_d;
      dv_q       <= dv_d;
      pe_q       <= pe_d;
      se_q       <= se_d;
    end
  end

  assign P_DATA     = p_data_q;
  assign Data_valid = dv_q;
  assign Par_err    = pe_q;
  assign Stp_err    = se_q;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed frames plus
// randomized frames against a frame-level reference model.
module tb_uart_rx;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       RX_IN = 1'b1;
  logic [5:0] Prescale = 6'd8;
  logic       PAR_EN = 1'b0;
  logic       PAR_TYP = 1'b0;
  logic [7:0] P_DATA;
  logic       Data_valid, Par_err, Stp_err;

  int n_tests = 0;
  int n_fail = 0;
  int cyc = 0;
  int dv_cnt = 0, pe_cnt = 0, se_cnt = 0;
  int dv_cyc[$];

  uart_rx #(.DATA_WIDTH(8)) dut (
    .CLK(CLK), .RST(RST), .RX_IN(RX_IN),
    .Prescale(Prescale), .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP),
    .P_DATA(P_DATA), .Data_valid(Data_valid),
    .Par_err(Par_err), .Stp_err(Stp_err)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  always @(negedge CLK) begin
    if (Data_valid === 1'b1) begin
      dv_cnt++;
      dv_cyc.push_back(cyc);
    end
    if (Par_err === 1'b1) pe_cnt++;
    if (Stp_err === 1'b1) se_cnt++;
  end

  task automatic clear_mon();
    dv_cnt = 0; pe_cnt = 0; se_cnt = 0;
    dv_cyc.delete();
  endtask

  task automatic drive_bit(input logic v, input int n);
    @(posedge CLK);
    #1 RX_IN = v;
    repeat (n - 1) @(posedge CLK);
  endtask

  task automatic send_frame(
    input logic [7:0] d, input logic [5:0] p,
    input logic pen, input logic ptyp,
    input logic pflip, input logic stopb,
    input logic scramble, input int gap,
    output int start_cyc
  );
    Prescale = p; PAR_EN = pen; PAR_TYP = ptyp;
    @(posedge CLK);
    #1 RX_IN = 1'b0;
    start_cyc = cyc;
    repeat (int'(p) - 1) @(posedge CLK);
    for (int i = 0; i < 8; i++) begin
      drive_bit(d[i], int'(p));
      if (scramble && i == 0) begin
        case ($urandom_range(0, 2))
          0: Prescale = 6'd8;
          1: Prescale = 6'd16;
          default: Prescale = 6'd32;
        endcase
        PAR_EN = 1'($urandom);
        PAR_TYP = 1'($urandom);
      end
    end
    Prescale = p; PAR_EN = pen; PAR_TYP = ptyp;
    if (pen) drive_bit((^d) ^ ptyp ^ pflip, int'(p));
    drive_bit(stopb, int'(p));
    if (gap > 0) drive_bit(1'b1, gap);
  endtask

  task automatic test_reset();
    #2 RST = 1'b0;
    #1;
    n_tests++;
    if (P_DATA !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_pdata got %h want 00", P_DATA);
    end
    n_tests++;
    if ({Data_valid, Par_err, Stp_err} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_pulses got %b want 000",
               {Data_valid, Par_err, Stp_err});
    end
    repeat (3) @(posedge CLK);
    #1 RST = 1'b1;
    repeat (4) @(posedge CLK);
  endtask

  task automatic test_odd_parity();
    int sc, lat;
    clear_mon();
    send_frame(8'h55, 6'd8, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 24, sc);
    lat = (dv_cyc.size() > 0) ? dv_cyc[0] - sc : -1;
    n_tests++;
    if (dv_cnt != 1 || pe_cnt != 0 || se_cnt != 0) begin
      n_fail++;
      $display("FAIL odd_par_pulses got dv=%0d pe=%0d se=%0d want 1 0 0",
               dv_cnt, pe_cnt, se_cnt);
    end
    n_tests++;
    if (P_DATA !== 8'h55) begin
      n_fail++;
      $display("FAIL odd_par_data got %h want 55", P_DATA);
    end
    n_tests++;
    if (lat != 10 * 8 + 4 + 6) begin
      n_fail++;
      $display("FAIL odd_par_latency got %0d want %0d", lat, 90);
    end
  endtask

  task automatic test_parity_error();
    int sc;
    clear_mon();
    send_frame(8'hA3, 6'd16, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 48, sc);
    n_tests++;
    if (dv_cnt != 0 || pe_cnt != 1 || se_cnt != 0) begin
      n_fail++;
      $display("FAIL par_err_pulses got dv=%0d pe=%0d se=%0d want 0 1 0",
               dv_cnt, pe_cnt, se_cnt);
    end
    n_tests++;
    if (P_DATA !== 8'h55) begin
      n_fail++;
      $display("FAIL par_err_data got %h want 55", P_DATA);
    end
  endtask

  task automatic test_stop_error();
    int sc;
    clear_mon();
    send_frame(8'h3C, 6'd32, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 96, sc);
    n_tests++;
    if (dv_cnt != 0 || pe_cnt != 0 || se_cnt != 1) begin
      n_fail++;
      $display("FAIL stp_err_pulses got dv=%0d pe=%0d se=%0d want 0 0 1",
               dv_cnt, pe_cnt, se_cnt);
    end
    n_tests++;
    if (P_DATA !== 8'h55) begin
      n_fail++;
      $display("FAIL stp_err_data got %h want 55", P_DATA);
    end
    clear_mon();
    send_frame(8'hC3, 6'd32, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 64, sc);
    n_tests++;
    if (dv_cnt != 1 || P_DATA !== 8'hC3) begin
      n_fail++;
      $display("FAIL stp_recover got dv=%0d data=%h want 1 c3",
               dv_cnt, P_DATA);
    end
  endtask

  task automatic test_glitch();
    int sc;
    clear_mon();
    Prescale = 6'd8; PAR_EN = 1'b0;
    drive_bit(1'b0, 2);
    drive_bit(1'b1, 40);
    n_tests++;
    if (dv_cnt + pe_cnt + se_cnt != 0) begin
      n_fail++;
      $display("FAIL glitch_pulses got dv=%0d pe=%0d se=%0d want 0 0 0",
               dv_cnt, pe_cnt, se_cnt);
    end
    send_frame(8'h81, 6'd8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 24, sc);
    n_tests++;
    if (dv_cnt != 1 || P_DATA !== 8'h81) begin
      n_fail++;
      $display("FAIL glitch_recover got dv=%0d data=%h want 1 81",
               dv_cnt, P_DATA);
    end
  endtask

  task automatic test_back_to_back();
    int sc, gapc;
    clear_mon();
    send_frame(8'h12, 6'd16, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0, sc);
    send_frame(8'h34, 6'd16, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 48, sc);
    gapc = (dv_cyc.size() > 1) ? dv_cyc[1] - dv_cyc[0] : -1;
    n_tests++;
    if (dv_cnt != 2 || P_DATA !== 8'h34) begin
      n_fail++;
      $display("FAIL b2b_pulses got dv=%0d data=%h want 2 34",
               dv_cnt, P_DATA);
    end
    n_tests++;
    if (gapc != 160) begin
      n_fail++;
      $display("FAIL b2b_spacing got %0d want 160", gapc);
    end
  endtask

  task automatic test_reset_midframe();
    int sc;
    logic [7:0] d;
    clear_mon();
    d = 8'hFF;
    Prescale = 6'd16; PAR_EN = 1'b0;
    drive_bit(1'b0, 16);
    for (int i = 0; i < 4; i++) drive_bit(d[i], 16);
    @(posedge CLK);
    #1 RX_IN = 1'b1;
    repeat (5) @(posedge CLK);
    #2 RST = 1'b0;
    #1;
    n_tests++;
    if (P_DATA !== 8'h00 || {Data_valid, Par_err, Stp_err} !== 3'b000) begin
      n_fail++;
      $display("FAIL midreset_async got data=%h pulses=%b want 00 000",
               P_DATA, {Data_valid, Par_err, Stp_err});
    end
    repeat (4) @(posedge CLK);
    #1 RST = 1'b1;
    repeat (200) @(posedge CLK);
    n_tests++;
    if (dv_cnt + pe_cnt + se_cnt != 0 || P_DATA !== 8'h00) begin
      n_fail++;
      $display("FAIL midreset_drop got dv=%0d pe=%0d se=%0d data=%h",
               dv_cnt, pe_cnt, se_cnt, P_DATA);
    end
    send_frame(8'h0F, 6'd16, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 48, sc);
    n_tests++;
    if (dv_cnt != 1 || P_DATA !== 8'h0F) begin
      n_fail++;
      $display("FAIL midreset_recover got dv=%0d data=%h want 1 0f",
               dv_cnt, P_DATA);
    end
  endtask

  task automatic test_random();
    logic [7:0] d, exp_data;
    logic [5:0] p;
    logic pen, ptyp, pflip, stopb, par_ok;
    int sc, lat, exp_lat, exp_dv, exp_pe, exp_se;
    exp_data = P_DATA === 8'h0F ? 8'h0F : 8'hxx;
    for (int it = 0; it < 12; it++) begin
      d = 8'($urandom);
      case ($urandom_range(0, 2))
        0: p = 6'd8;
        1: p = 6'd16;
        default: p = 6'd32;
      endcase
      pen = 1'($urandom);
      ptyp = 1'($urandom);
      pflip = ($urandom_range(0, 3) == 0);
      stopb = ($urandom_range(0, 3) != 0);
      par_ok = !(pen && pflip);
      exp_dv = (par_ok && stopb) ? 1 : 0;
      exp_pe = par_ok ? 0 : 1;
      exp_se = stopb ? 0 : 1;
      if (exp_dv == 1) exp_data = d;
      exp_lat = (9 + int'(pen)) * int'(p) + int'(p) / 2 + 6;
      clear_mon();
      send_frame(d, p, pen, ptyp, pflip, stopb, 1'b1, 3 * int'(p), sc);
      n_tests++;
      if (dv_cnt != exp_dv || pe_cnt != exp_pe || se_cnt != exp_se) begin
        n_fail++;
        $display("FAIL rand%0d_pulses got dv=%0d pe=%0d se=%0d want %0d %0d %0d",
                 it, dv_cnt, pe_cnt, se_cnt, exp_dv, exp_pe, exp_se);
      end
      n_tests++;
      if (P_DATA !== exp_data) begin
        n_fail++;
        $display("FAIL rand%0d_data got %h want %h", it, P_DATA, exp_data);
      end
      if (exp_dv == 1) begin
        lat = (dv_cyc.size() > 0) ? dv_cyc[0] - sc : -1;
        n_tests++;
        if (lat != exp_lat) begin
          n_fail++;
          $display("FAIL rand%0d_latency got %0d want %0d", it, lat, exp_lat);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_odd_parity();
    test_parity_error();
    test_stop_error();
    test_glitch();
    test_back_to_back();
    test_reset_midframe();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
